mod_counter: RTL
================

Name: mod_counter

Overview:
- Parametrised successor to the team's 4-bit free-running counter.
- Adds configurable width and modulus, up/down counting, count enable, synchronous parallel load, and a per-cycle wrap/saturate mode.
- Produces a registered terminal-event pulse and a sticky overflow flag.
- Used as the general-purpose timing/event counter. Two instances can be chained by driving one instance's en from the other's evt.

Parameters:
- WIDTH, 4, counter width in bits (at least 2).
- MAX_VAL, 2**WIDTH-1, highest count value (modulus is MAX_VAL+1); must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- PRESCALE, 4, enable divide ratio (at least 2); used only when MOD_COUNTER_PRESCALE_EN is defined.

Ports:
- clock  input  1  rising-edge clock
- clear_n  input  1  asynchronous active-low reset
- en  input  1  count enable; steps the counter by one per cycle
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load strobe
- load_val  input  WIDTH  value to load
- sat_mode  input  1  boundary behaviour: 1 = saturate, 0 = wrap
- ovf_clr  input  1  clears the sticky overflow flag
- count  output  WIDTH  current count (registered)
- evt  output  1  one-cycle pulse, registered, on a boundary event
- ovf  output  1  sticky flag: a wrap has occurred

Behaviour:
- Reset: clear_n low asynchronously forces count=0, evt=0, ovf=0, and the prescaler counter to 0. Release is synchronous to the next rising edge of clock.
- Priority per rising edge: load > en step > hold.
- Load:
  - count <= min(load_val, MAX_VAL).
  - evt=0 that cycle; ovf unaffected.
  - Load also resets the prescaler counter.
- Step (en=1, load=0), with the "step qualifier" being en (or the prescaler tick when the optional feature is compiled in):
  - Up, count<MAX_VAL: count+1.
  - Up, count==MAX_VAL, sat_mode=0: count <= 0; evt<=1; ovf<=1.
  - Up, count==MAX_VAL, sat_mode=1: count holds; evt<=1; ovf unchanged.
  - Down, count>0: count-1.
  - Down, count==0, sat_mode=0: count <= MAX_VAL; evt<=1; ovf<=1.
  - Down, count==0, sat_mode=1: count holds; evt<=1; ovf unchanged.
- evt timing:
  - evt is high exactly in the cycle after the boundary edge, and low otherwise.
  - While held saturated with en=1, evt stays high every cycle, because each step is a boundary event.
- Arithmetic:
  - All compares are unsigned and WIDTH bits wide.
  - There is no intermediate overflow, because the MAX_VAL compare precedes the increment.
- ovf:
  - Set by any wrap.
  - Cleared by ovf_clr=1.
  - If a wrap and ovf_clr occur on the same edge, the set wins (ovf=1).
- Changing up or sat_mode mid-count takes effect on the next step; there is no other state.
- Reset asserted mid-count overrides everything immediately; no partial update survives.

Optional Feature:
- Macro: MOD_COUNTER_PRESCALE_EN
- Defined:
  - An internal divider counts en-qualified cycles from 0 to PRESCALE-1.
  - The counter steps only on the cycle where the divider equals PRESCALE-1 and en=1; the divider then returns to 0.
  - en=0 freezes the divider.
  - load clears the divider.
- Undefined:
  - The divider logic is absent.
  - Every en=1 cycle is a step.
  - The PRESCALE parameter is ignored.

Decomposition:
- Package mod_counter_pkg:
  - dir_e enum (DIR_DOWN=0, DIR_UP=1).
  - bnd_e enum (BND_WRAP=0, BND_SAT=1).
  - Function clamp_load(val, max) used by the load path.
- One sub-module, mod_counter_prescaler (parameter PRESCALE; ports clock, clear_n, en, sync_clr, tick).
  - Instantiated only under MOD_COUNTER_PRESCALE_EN.
- Remaining next-state logic stays in mod_counter.

Test Plan:
All tests use WIDTH=4, MAX_VAL=9.
1. Reset and count up, wrap:
   - Stimulus: clear_n=0 for 2 cycles, then release; en=1, up=1, sat_mode=0 for 12 cycles.
   - Response: count runs 0..9, 0, 1. evt is high one cycle after the 9->0 edge. ovf=1 from then on.
2. Down and saturate:
   - Stimulus: load 3, then en=1, up=0, sat_mode=1 for 6 cycles.
   - Response: count runs 3, 2, 1, 0, 0, 0. evt is high on each step taken at 0. ovf stays 0.
3. Load clamp and priority:
   - Stimulus: load_val=14 with load=1 and en=1 in the same cycle.
   - Response: count=9; no step; evt=0.
4. Sticky flag:
   - Stimulus: wrap 9->0 with ovf_clr=1 on the same edge, then ovf_clr=1 alone on the next cycle.
   - Response: ovf=1 after the first edge, then ovf=0.
5. Async reset mid-count:
   - Stimulus: count=6; pulse clear_n low between clock edges.
   - Response: count=0, evt=0, ovf=0 immediately, with no clock edge needed.
6. Prescaler, with MOD_COUNTER_PRESCALE_EN defined and PRESCALE=4:
   - Stimulus: en=1, up=1 for 12 cycles from 0.
   - Response: count steps 0->1->2->3, one step every 4th cycle. A 2-cycle en=0 gap delays the next step by exactly 2 cycles.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the mod_counter block.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package mod_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        BND_WRAP = 1'b0,
        BND_SAT  = 1'b1
    } bnd_e;

    // Wide enough for any counter width the block is built with (WIDTH <= 31).
    localparam int CLAMP_W = 32;

    // Limit a parallel-load value to the highest legal count.
    function automatic logic [CLAMP_W-1:0] clamp_load(
        input logic [CLAMP_W-1:0] val,
        input logic [CLAMP_W-1:0] max
    );
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/mod_counter_prescaler.sv
// Enable divider: asserts tick on every PRESCALE-th en-qualified cycle.
// Latency: tick is combinational from en and the registered divider state.
// Backpressure: en=0 freezes the divider; sync_clr returns it to 0.
module mod_counter_prescaler
    import mod_counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clock,
    input  logic clear_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int              DIV_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);

    logic [DIV_W-1:0] r_div;
    logic             w_at_last;

    assign w_at_last = (r_div == DIV_LAST);
    assign tick      = en && w_at_last;

    // Divider: count en cycles 0..PRESCALE-1, restart after the last one or on clear.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_div <= '0;
        end else if (sync_clr) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= w_at_last ? '0 : r_div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with load, wrap/saturate, boundary pulse and sticky overflow.
// Latency: count/evt/ovf registered, updated one clock after the qualifying inputs.
// Backpressure: none; en (prescaled when MOD_COUNTER_PRESCALE_EN is defined) gates steps.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = (2 ** WIDTH) - 1,
    parameter int PRESCALE = 4
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             evt,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;
    logic             r_evt;
    logic             r_ovf;

    logic             w_step;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_evt_nxt;
    logic             w_wrap;
    dir_e             w_dir;
    bnd_e             w_bnd;

`ifdef MOD_COUNTER_PRESCALE_EN
    // Load also restarts the divider so the first step after a load is a full period away.
    mod_counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock    (clock),
        .clear_n  (clear_n),
        .en       (en),
        .sync_clr (load),
        .tick     (w_step)
    );
`else
    logic w_unused_prescale;
    assign w_unused_prescale = (PRESCALE > 1);
    assign w_step            = en;
`endif

    assign w_dir          = dir_e'(up);
    assign w_bnd          = bnd_e'(sat_mode);
    assign w_load_clamped = WIDTH'(clamp_load(CLAMP_W'(load_val), CLAMP_W'(MAX_VAL)));

    // Next count: load beats step beats hold; boundary compare precedes any +/-1.
    always_comb begin
        w_count_nxt = r_count;
        w_evt_nxt   = 1'b0;
        w_wrap      = 1'b0;
        if (load) begin
            w_count_nxt = w_load_clamped;
        end else if (w_step) begin
            if (w_dir == DIR_UP) begin
                if (r_count == MAX_C) begin
                    w_evt_nxt = 1'b1;
                    if (w_bnd == BND_WRAP) begin
                        w_count_nxt = '0;
                        w_wrap      = 1'b1;
                    end
                end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end else begin
                if (r_count == '0) begin
                    w_evt_nxt = 1'b1;
                    if (w_bnd == BND_WRAP) begin
                        w_count_nxt = MAX_C;
                        w_wrap      = 1'b1;
                    end
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
        end
    end

    // State registers; a wrap on the same edge as ovf_clr leaves ovf set.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_count <= '0;
            r_evt   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_evt   <= w_evt_nxt;
            if (w_wrap) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign count = r_count;
    assign evt   = r_evt;
    assign ovf   = r_ovf;

endmodule
